// File: rtl/spi_master_gen2.sv
// SPI master with run-time CPOL/CPHA, burst slave-select hold and a fixed sck divider.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN adds the lsb_first input.
module spi_master_gen2 #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_SS  = 1,
  localparam int unsigned SsIdxW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              hold,
  input  logic [SsIdxW-1:0] ss_idx,
  input  logic [DATA_W-1:0] data_in,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_SS-1:0] ss,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              new_data
);

  localparam int unsigned CntW  = $clog2(CLK_DIV + 1);
  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [EdgeW-1:0]   edge_q, edge_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [NUM_SS-1:0]  ss_q, ss_d;
  logic               ss_held_q, ss_held_d;
  logic               cpha_q, cpha_d;
  logic               hold_q, hold_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               new_data_q, new_data_d;
  logic [NUM_SS-1:0]  ss_sel;
  logic               sample_edge;
  logic               lsb_now, lsb_cur;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_now = lsb_first;
  assign lsb_cur = lsb_q;
`else
  assign lsb_now = 1'b0;
  assign lsb_cur = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  // Out-of-range indices leave every line deasserted.
  always_comb begin
    ss_sel = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (32'(ss_idx) == i) ss_sel[i] = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    ss_d        = ss_q;
    ss_held_d   = ss_held_q;
    cpha_d      = cpha_q;
    hold_d      = hold_q;
    data_out_d  = data_out_q;
    new_data_d  = 1'b0;
    sample_edge = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_d       = lsb_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          cnt_d   = '0;
          edge_d  = '0;
          sck_d   = cpol;
          cpha_d  = cpha;
          hold_d  = hold;
          rx_d    = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
          lsb_d   = lsb_now;
`endif
          if (!ss_held_q) ss_d = ss_sel;
          // cpha=0 drives the first bit immediately; cpha=1 waits for the first leading edge.
          if (cpha) begin
            tx_d   = data_in;
            mosi_d = 1'b0;
          end else begin
            tx_d   = shift_tx(data_in, lsb_now);
            mosi_d = first_bit(data_in, lsb_now);
          end
        end
      end
      StSetup: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StXfer: begin
        if (cnt_q == CntLast) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + EdgeW'(1);
          // Even edge indices are leading edges; cpha selects which kind samples.
          sample_edge = ~edge_q[0] ^ cpha_q;
          if (sample_edge) begin
            rx_d = shift_rx(rx_q, miso, lsb_cur);
          end else begin
            mosi_d = first_bit(tx_q, lsb_cur);
            tx_d   = shift_tx(tx_q, lsb_cur);
          end
          if (edge_q == EdgeLast) begin
            state_d    = StDone;
            data_out_d = rx_d;
            new_data_d = 1'b1;
            if (hold_q) begin
              ss_held_d = 1'b1;
            end else begin
              ss_d      = '1;
              ss_held_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      edge_q     <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      ss_q       <= '1;
      ss_held_q  <= 1'b0;
      cpha_q     <= 1'b0;
      hold_q     <= 1'b0;
      data_out_q <= '0;
      new_data_q <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      ss_q       <= ss_d;
      ss_held_q  <= ss_held_d;
      cpha_q     <= cpha_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      new_data_q <= new_data_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_q      <= lsb_d;
`endif
    end
  end

  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign ss       = ss_q;
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_master_gen2.sv
// Self-checking bench for spi_master_gen2: the bench acts as SPI slave and predicts results
// from the protocol rules (bit order, edge roles, slave-select hold) rather than RTL state.
module tb_spi_master_gen2;

  localparam int unsigned DataW   = 8;
  localparam int unsigned ClkDiv  = 4;
  localparam int unsigned NumSs   = 4;
  // Counting the cycle that presents start as cycle 1.
  localparam int unsigned Latency = 1 + ClkDiv * (2 * DataW + 1) + 1;

  logic       clk;
  logic       rst, start, cpol, cpha, hold;
  logic [1:0] ss_idx;
  logic [7:0] data_in, data_out;
  logic       miso, mosi, sck, busy, new_data;
  logic [3:0] ss;
  logic       lsb_mode, loop_en, slave_bit;
  logic       held;
  logic [3:0] held_vec;
  int         n_checks, n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : slave_bit;

  spi_master_gen2 #(
    .DATA_W (DataW),
    .CLK_DIV(ClkDiv),
    .NUM_SS (NumSs)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cpol     (cpol),
    .cpha     (cpha),
    .hold     (hold),
    .ss_idx   (ss_idx),
    .data_in  (data_in),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_mode),
`endif
    .miso     (miso),
    .mosi     (mosi),
    .sck      (sck),
    .ss       (ss),
    .data_out (data_out),
    .busy     (busy),
    .new_data (new_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] sel_vec(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  // k-th bit on the wire for a given word and bit order.
  function automatic logic bit_at(input logic [7:0] w, input int k, input logic lsb);
    return lsb ? w[k] : w[7-k];
  endfunction

  // glitch: >0 pulses start after that many sck edges, 0 pulses it in the DONE cycle.
  task automatic run_xfer(input logic pol, input logic pha, input logic hld, input logic [1:0] idx,
                          input logic [7:0] din, input logic [7:0] sw, input logic lb,
                          input logic lsb, input int glitch);
    logic [3:0] ss_exp, ss_end;
    logic [7:0] mosi_word, exp_rx;
    logic       sck_prev, leading, done_seen, ss_bad, busy_bad;
    int         edges, n_nd, sidx, ridx, lat;
    ss_exp = held ? held_vec : sel_vec(idx);
    ss_end = hld ? ss_exp : 4'hF;
    exp_rx = lb ? din : sw;
    @(negedge clk);
    check_eq("ss_idle", ss, held ? held_vec : 4'hF);
    cpol = pol; cpha = pha; hold = hld; ss_idx = idx; data_in = din;
    lsb_mode = lsb; loop_en = lb;
    sidx = pha ? -1 : 0;
    slave_bit = pha ? 1'b0 : bit_at(sw, 0, lsb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_rise", busy, 1);
    check_eq("sck_setup", sck, pol);
    check_eq("ss_active", ss, ss_exp);
    sck_prev = sck; edges = 0; n_nd = 0; ridx = 0; mosi_word = '0;
    done_seen = 1'b0; ss_bad = 1'b0; busy_bad = 1'b0;
    lat = 2;
    while (!done_seen && lat < 4 * Latency) begin
      start = 1'b0;
      if (sck !== sck_prev) begin
        leading = (sck !== pol);
        if (leading ^ pha) begin
          if (lsb) mosi_word[ridx] = mosi;
          else mosi_word[7-ridx] = mosi;
          ridx++;
        end else begin
          sidx++;
          if (sidx < 8) slave_bit = bit_at(sw, sidx, lsb);
        end
        edges++;
        if (edges == glitch) start = 1'b1;
      end
      sck_prev = sck;
      if (new_data) begin
        done_seen = 1'b1;
        n_nd++;
        check_eq("latency", lat, Latency);
        check_eq("data_out", data_out, exp_rx);
        check_eq("mosi_bits", mosi_word, din);
        check_eq("sck_edges", edges, 2 * DataW);
        check_eq("ss_done", ss, ss_end);
        if (glitch == 0) start = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (ss !== ss_exp) ss_bad = 1'b1;
        @(negedge clk);
        lat++;
      end
    end
    check_eq("done_seen", done_seen, 1);
    check_eq("ss_stable", ss_bad, 0);
    check_eq("busy_hold", busy_bad, 0);
    @(negedge clk);
    start = 1'b0;
    check_eq("nd_pulse", new_data, 0);
    check_eq("busy_fall", busy, 0);
    check_eq("sck_idle", sck, pol);
    check_eq("ss_after", ss, ss_end);
    check_eq("data_keep", data_out, exp_rx);
    repeat (3) begin
      @(negedge clk);
      if (new_data) n_nd++;
      if (busy) busy_bad = 1'b1;
    end
    check_eq("nd_count", n_nd, 1);
    check_eq("busy_late", busy_bad, 0);
    held = hld;
    held_vec = hld ? ss_exp : 4'hF;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ss"}, ss, 4'hF);
    check_eq({tag, "_sck"}, sck, 0);
    check_eq({tag, "_mosi"}, mosi, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_nd"}, new_data, 0);
    check_eq({tag, "_dout"}, data_out, 0);
  endtask

  task automatic run_abort();
    logic sck_prev, busy_bad;
    int   edges, n_nd, guard;
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; hold = 1'b1; ss_idx = 2'd1; data_in = 8'h3C;
    lsb_mode = 1'b0; loop_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sck_prev = sck; edges = 0; n_nd = 0; guard = 0; busy_bad = 1'b0;
    while (edges < 7 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (sck !== sck_prev) edges++;
      sck_prev = sck;
      if (new_data) n_nd++;
    end
    check_eq("abort_reach", edges, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("abort");
    repeat (80) begin
      @(negedge clk);
      if (new_data) n_nd++;
      if (busy) busy_bad = 1'b1;
    end
    check_eq("abort_no_nd", n_nd, 0);
    check_eq("abort_idle", busy_bad, 0);
    held = 1'b0;
    held_vec = 4'hF;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; hold = 1'b0; ss_idx = '0;
    data_in = '0; lsb_mode = 1'b0; loop_en = 1'b0; slave_bit = 1'b0;
    held = 1'b0; held_vec = 4'hF;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;

    // Mode 0 loopback of 0x5C.
    run_xfer(1'b0, 1'b0, 1'b0, 2'd0, 8'h5C, 8'h00, 1'b1, 1'b0, -1);
    // Mode 3, slave answers 0xA5.
    run_xfer(1'b1, 1'b1, 1'b0, 2'd1, 8'h3A, 8'hA5, 1'b0, 1'b0, -1);
    // Burst on line 2; second ss_idx must be ignored.
    run_xfer(1'b0, 1'b0, 1'b1, 2'd2, 8'h11, 8'hC3, 1'b0, 1'b0, -1);
    run_xfer(1'b0, 1'b0, 1'b0, 2'd0, 8'h22, 8'h3C, 1'b0, 1'b0, -1);
    // Start during bit 3 and during DONE must both be dropped.
    run_xfer(1'b0, 1'b0, 1'b0, 2'd3, 8'h96, 8'h69, 1'b0, 1'b0, 7);
    run_xfer(1'b1, 1'b0, 1'b0, 2'd1, 8'hE1, 8'h1E, 1'b0, 1'b0, 0);
`ifdef SPI_MASTER_LSB_FIRST_EN
    run_xfer(1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 8'h00, 1'b1, 1'b1, -1);
    run_xfer(1'b0, 1'b1, 1'b0, 2'd3, 8'hB4, 8'h4D, 1'b0, 1'b1, -1);
`endif

    for (int i = 0; i < 10; i++) begin
      logic lsb_r;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_r = 1'($urandom);
`else
      lsb_r = 1'b0;
`endif
      run_xfer(1'($urandom), 1'($urandom), (i < 9) ? 1'($urandom) : 1'b0, 2'($urandom),
               8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), lsb_r, -1);
    end

    run_abort();
    run_xfer(1'b0, 1'b1, 1'b0, 2'd2, 8'h7E, 8'h81, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_gen2.md
SPI_MASTER_GEN2 -- requirements
Module: spi_master_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per transfer (range 4..32).
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per sck half-period (>=1).
REQ-003 SHALL have parameter NUM_SS, default 1, meaning number of slave-select lines (1..8).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  transfer request, sampled only while busy=0.
REQ-007 SHALL have port cpol  input  1  sck idle level, latched at start.
REQ-008 SHALL have port cpha  input  1  clock phase, latched at start.
REQ-009 SHALL have port hold  input  1  keep ss asserted after this transfer (burst), latched at start.
REQ-010 SHALL have port ss_idx  input  max(1,$clog2(NUM_SS))  slave select index, latched at start.
REQ-011 SHALL have port data_in  input  DATA_W  transmit word, latched at start.
REQ-012 SHALL have port miso  input  1  serial data from slave.
REQ-013 SHALL have port mosi  output  1  serial data to slave.
REQ-014 SHALL have port sck  output  1  serial clock.
REQ-015 SHALL have port ss  output  NUM_SS  active-low slave selects.
REQ-016 SHALL have port data_out  output  DATA_W  last received word, stable until next new_data.
REQ-017 SHALL have port busy  output  1  high from cycle after accepted start until DONE exits.
REQ-018 SHALL have port new_data  output  1  one-cycle pulse when data_out updates.

Function
REQ-019 SHALL implement states IDLE, SETUP, XFER, DONE; IDLE->SETUP on start&!busy; SETUP->XFER after CLK_DIV cycles; XFER->DONE after 2*DATA_W sck edges; DONE->IDLE after 1 cycle.
REQ-020 SHALL assert ss[ss_idx] low on entering SETUP; ss_idx >= NUM_SS SHALL select no line but still run the transfer.
REQ-021 SHALL keep sck at latched cpol in IDLE, SETUP, DONE; toggle every CLK_DIV cycles in XFER.
REQ-022 cpha=0: mosi SHALL present MSB from SETUP entry, sample miso on leading edges, shift mosi on trailing edges.
REQ-023 cpha=1: mosi SHALL shift on leading edges (first bit at first leading edge), sample miso on trailing edges.
REQ-024 Transfer latency SHALL be 1+CLK_DIV*(2*DATA_W+1)+1 clk cycles from start to new_data.
REQ-025 In DONE, data_out SHALL load the received shift register and new_data SHALL pulse for exactly that cycle.
REQ-026 Latched hold=0: ss SHALL deassert (all high) in DONE; hold=1: ss SHALL stay low through IDLE until a transfer with hold=0 completes or rst.
REQ-027 start during busy=1 SHALL be ignored (not queued); start in the DONE cycle SHALL be ignored.
REQ-028 While ss held from a burst, a new start SHALL skip ss re-assertion but still spend CLK_DIV cycles in SETUP; latched ss_idx SHALL be ignored until ss releases.
REQ-029 Half-period counter SHALL be $clog2(CLK_DIV+1) bits, wrapping to 0 at CLK_DIV-1.

Reset
REQ-030 rst SHALL force IDLE, ss all-ones, sck=0, mosi=0, busy=0, new_data=0, data_out=0, clear hold latch.
REQ-031 rst mid-transfer SHALL abort with no new_data pulse; cpol latch resets to 0.

Configuration
REQ-032 With SPI_MASTER_LSB_FIRST_EN defined, an added input lsb_first (1 bit, latched at start) SHALL select LSB-first shift/assembly when 1.
REQ-033 Without SPI_MASTER_LSB_FIRST_EN, port lsb_first SHALL not exist and all transfers SHALL be MSB-first.

Verification
REQ-034 DATA_W=8, CLK_DIV=4, mode 0, data_in=0x5C, miso looped from mosi -> mosi sequence 0,1,0,1,1,1,0,0; data_out=0x5C; new_data at cycle 70 after start.
REQ-035 Mode 3 (cpol=1,cpha=1), slave returns 0xA5 -> sck idles 1, data_out=0xA5, ss high after DONE.
REQ-036 Burst: hold=1 send 0x11, then hold=0 send 0x22 to ss_idx=2 (NUM_SS=4) -> ss[2] low continuously across both, two new_data pulses, ss=4'b1111 after second.
REQ-037 start pulsed at bit 3 of an active transfer -> ignored, single new_data, busy never drops early.
REQ-038 rst asserted at sck edge 7 -> next cycle all outputs at reset values, no new_data; subsequent start works normally.
REQ-039 SPI_MASTER_LSB_FIRST_EN defined, lsb_first=1, data_in=0x01 -> mosi first bit 1, remaining 0; loopback data_out=0x01.
